varredura_matriz: RTL

- Row-scan driver for the 7x5 LED matrix.
- Generates the 3-bit row counter `contador` that feeds the combinational frame decoders (one 5-bit `colunas` pattern per row).
- Latches the decoder's column pattern back in, and drives one-hot row enables plus registered columns, with a blanking gap between rows.
- Accepts frame-change requests over a valid/ready handshake and applies them only at a frame boundary, so no frame is ever shown torn.

---
 rtl/varredura_matriz.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/varredura_matriz.sv
// Row-scan driver for a 7x5 LED matrix: row counter, blanking gap, and frame switching only at frame boundaries.
// Optional macro VARREDURA_BRILHO_EN adds a 3-bit `brilho` input that sets the lit fraction of each row.
module varredura_matriz #(
  parameter int DIV   = 4,
  parameter int BLANK = 1,
  parameter int ROWS  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] colunas_in,
  input  logic [1:0] quadro_req,
  input  logic       quadro_valid,
`ifdef VARREDURA_BRILHO_EN
  input  logic [2:0] brilho,
`endif
  output logic       quadro_ready,
  output logic       quadro_ack,
  output logic [1:0] quadro_atual,
  output logic [2:0] contador,
  output logic [7:0] linhas,
  output logic [4:0] colunas,
  output logic       frame_start
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SCAN  = 1'b1;

  // A zero blanking length behaves as a single blank cycle.
  localparam logic [7:0]  BLANK_M1 = (BLANK <= 1) ? 8'd0 : 8'(BLANK - 1);
  localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
  localparam logic [2:0]  ROWS_M1  = 3'(ROWS - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  blank_cnt_q, blank_cnt_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  contador_q, contador_d;
  logic [7:0]  linhas_q, linhas_d;
  logic [4:0]  colunas_q, colunas_d;
  logic [1:0]  atual_q, atual_d;
  logic [1:0]  pend_q, pend_d;
  logic        ready_q, ready_d;
  logic        ack_q, ack_d;
  logic        fstart_q, fstart_d;

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    presc_d     = presc_q;
    contador_d  = contador_q;
    linhas_d    = linhas_q;
    colunas_d   = colunas_q;
    atual_d     = atual_q;
    pend_d      = pend_q;
    ready_d     = ready_q;
    ack_d       = 1'b0;
    fstart_d    = 1'b0;

    case (state_q)
      ST_BLANK: begin
        blank_cnt_d = blank_cnt_q + 8'd1;
        if (blank_cnt_q == BLANK_M1) begin
          state_d   = ST_SCAN;
          presc_d   = '0;
          colunas_d = colunas_in;
          linhas_d  = 8'd1 << contador_q;
          fstart_d  = (contador_q == 3'd0);
        end
      end
      default: begin
        presc_d = presc_q + 16'd1;
        if (presc_q == DIV_M1) begin
          state_d     = ST_BLANK;
          blank_cnt_d = '0;
          linhas_d    = '0;
          colunas_d   = '0;
          if (contador_q == ROWS_M1) begin
            contador_d = '0;
            // Frame boundary: swap in the pending frame so row 0 is the first row decoded from it.
            if (!ready_q) begin
              atual_d = pend_q;
              ready_d = 1'b1;
              ack_d   = 1'b1;
            end
          end else begin
            contador_d = contador_q + 3'd1;
          end
        end
      end
    endcase

    // Only possible while ready, so it never collides with the apply above.
    if (quadro_valid && ready_q) begin
      pend_d  = quadro_req;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BLANK;
      blank_cnt_q <= '0;
      presc_q     <= '0;
      contador_q  <= '0;
      linhas_q    <= '0;
      colunas_q   <= '0;
      atual_q     <= '0;
      pend_q      <= '0;
      ready_q     <= 1'b1;
      ack_q       <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      presc_q     <= presc_d;
      contador_q  <= contador_d;
      linhas_q    <= linhas_d;
      colunas_q   <= colunas_d;
      atual_q     <= atual_d;
      pend_q      <= pend_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      fstart_q    <= fstart_d;
    end
  end

`ifdef VARREDURA_BRILHO_EN
  logic [31:0] on_raw, on_time;
  logic        lit;

  // Gate is combinational on brilho so a change lands inside the current row.
  always_comb begin
    on_raw  = ((32'(brilho) + 32'd1) * 32'(DIV)) >> 3;
    on_time = (on_raw == 32'd0) ? 32'd1 : on_raw;
    lit     = (state_q == ST_SCAN) && ({16'd0, presc_q} < on_time);
  end

  assign linhas  = lit ? linhas_q  : '0;
  assign colunas = lit ? colunas_q : '0;
`else
  assign linhas  = linhas_q;
  assign colunas = colunas_q;
`endif

  assign contador     = contador_q;
  assign quadro_atual = atual_q;
  assign quadro_ready = ready_q;
  assign quadro_ack   = ack_q;
  assign frame_start  = fstart_q;

endmodule
